// File: rtl/param_file_register_if.sv
// Bus bundle for param_file_register: write/reserve requests flow in, read data and
// scoreboard status flow out. Clock and reset stay outside as plain ports.
interface param_file_register_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we;
   logic              reg_dst;
   logic [ADDR_W-1:0] write0_addr;
   logic [ADDR_W-1:0] write1_addr;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] read0_addr;
   logic [ADDR_W-1:0] read1_addr;
   logic [DATA_W-1:0] read0_data;
   logic [DATA_W-1:0] read1_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              read0_busy;
   logic              read1_busy;
   logic [ADDR_W:0]   busy_count;

   modport master (
      output we, reg_dst, write0_addr, write1_addr, write_data,
      output read0_addr, read1_addr, rsv_en, rsv_addr,
      input  read0_data, read1_data, read0_busy, read1_busy, busy_count
   );

   modport slave (
      input  we, reg_dst, write0_addr, write1_addr, write_data,
      input  read0_addr, read1_addr, rsv_en, rsv_addr,
      output read0_data, read1_data, read0_busy, read1_busy, busy_count
   );
endinterface

// File: rtl/param_file_register.sv
// DEPTH x DATA_W register file: two combinational read ports, one write port with reg_dst
// address select, optional hardwired r0, optional write bypass, and a busy scoreboard.
module pfr_read_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                                rst_all,
   input  logic [ADDR_W-1:0]                   addr,
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  regs,
   input  logic [(1<<ADDR_W)-1:0]              busy,
   input  logic                                wr_ok,
   input  logic [ADDR_W-1:0]                   wa,
   input  logic [DATA_W-1:0]                   wdata,
   input  logic                                rsv_en,
   input  logic [ADDR_W-1:0]                   rsv_addr,
   output logic [DATA_W-1:0]                   data,
   output logic                                busy_o
);
   always_comb begin
      data   = regs[addr];
      busy_o = busy[addr];
      // Forwarded value is owned by whoever reserves the same register this cycle.
      if (BYPASS != 0 && rst_all && wr_ok && wa == addr) begin
         data   = wdata;
         busy_o = rsv_en && (rsv_addr == wa);
      end
      if (ZERO_REG != 0 && addr == '0) begin
         data   = '0;
         busy_o = 1'b0;
      end
   end
endmodule

module param_file_register #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                  clk,
   input logic                  rst_all,
   param_file_register_if.slave bus
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NUM_RD = 2;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]             busy_q, busy_d;
   logic [ADDR_W:0]              busy_count_q, busy_count_d;

   logic [ADDR_W-1:0] wa;
   logic              wr_ok;
   logic              rsv_ok;
   logic              busy_inc;
   logic              busy_dec;

   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]             rd_busy;

   always_comb begin
      wa     = bus.reg_dst ? bus.write1_addr : bus.write0_addr;
      wr_ok  = bus.we && !(ZERO_REG != 0 && wa == '0);
      rsv_ok = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);

      regs_d = regs_q;
      if (wr_ok) regs_d[wa] = bus.write_data;

      // Reserve is applied after the retire so a same-address pair leaves the bit set.
      busy_d = busy_q;
      if (wr_ok)  busy_d[wa]           = 1'b0;
      if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;

      busy_inc = rsv_ok && !busy_q[bus.rsv_addr];
      busy_dec = wr_ok && busy_q[wa] && !(rsv_ok && bus.rsv_addr == wa);

      busy_count_d = busy_count_q;
      case ({busy_inc, busy_dec})
         2'b10:   busy_count_d = busy_count_q + CNT_ONE;
         2'b01:   busy_count_d = busy_count_q - CNT_ONE;
         default: busy_count_d = busy_count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_all) begin
      if (!rst_all) begin
         regs_q       <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign rd_addr = {bus.read1_addr, bus.read0_addr};

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      pfr_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .rst_all  (rst_all),
         .addr     (rd_addr[i]),
         .regs     (regs_q),
         .busy     (busy_q),
         .wr_ok    (wr_ok),
         .wa       (wa),
         .wdata    (bus.write_data),
         .rsv_en   (bus.rsv_en),
         .rsv_addr (bus.rsv_addr),
         .data     (rd_data[i]),
         .busy_o   (rd_busy[i])
      );
   end

   assign bus.read0_data = rd_data[0];
   assign bus.read1_data = rd_data[1];
   assign bus.read0_busy = rd_busy[0];
   assign bus.read1_busy = rd_busy[1];
   assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_param_file_register.sv
// Scoreboard bench: two builds (r0+bypass, plain) share one stimulus stream and are
// checked against an array-based model of the register file and busy set.
module tb_param_file_register;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_all = 1'b0;
   always #5 clk = ~clk;

   param_file_register_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
   param_file_register_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

   assign ifb.we          = ifa.we;
   assign ifb.reg_dst     = ifa.reg_dst;
   assign ifb.write0_addr = ifa.write0_addr;
   assign ifb.write1_addr = ifa.write1_addr;
   assign ifb.write_data  = ifa.write_data;
   assign ifb.read0_addr  = ifa.read0_addr;
   assign ifb.read1_addr  = ifa.read1_addr;
   assign ifb.rsv_en      = ifa.rsv_en;
   assign ifb.rsv_addr    = ifa.rsv_addr;

   param_file_register #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_all(rst_all), .bus(ifa.slave));
   param_file_register #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst_all(rst_all), .bus(ifb.slave));

   typedef struct {
      logic [1:0][DW-1:0] d0;
      logic [1:0][DW-1:0] d1;
      logic [1:0]         b0;
      logic [1:0]         b1;
      logic [1:0][AW:0]   cnt;
      string              tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Model: index 0 mirrors dut_a (r0 hardwired, bypass), index 1 mirrors dut_b.
   logic [DW-1:0] mem [2][DEPTH];
   bit            bsy [2][DEPTH];

   bit            c_rst, c_we, c_rsv;
   logic [AW-1:0] c_wa, c_ra;
   logic [DW-1:0] c_wd;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void exp_rd(input int m, input logic [AW-1:0] a,
                                  output logic [DW-1:0] d, output logic b);
      bit zr;
      bit byp;
      zr  = (m == 0);
      byp = (m == 0);
      if (!c_rst || (zr && a == 0)) begin
         d = '0;
         b = 1'b0;
      end else if (byp && c_we && !(zr && c_wa == 0) && c_wa == a) begin
         d = c_wd;
         b = c_rsv && (c_ra == c_wa);
      end else begin
         d = mem[m][a];
         b = bsy[m][a];
      end
   endfunction

   task automatic step(input bit rst, input bit we, input bit dst,
                       input logic [AW-1:0] w0, input logic [AW-1:0] w1, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input bit rsv, input logic [AW-1:0] ra, input string tag);
      exp_t e;
      int   pc;
      rst_all          = rst;
      ifa.we           = we;
      ifa.reg_dst      = dst;
      ifa.write0_addr  = w0;
      ifa.write1_addr  = w1;
      ifa.write_data   = wd;
      ifa.read0_addr   = r0;
      ifa.read1_addr   = r1;
      ifa.rsv_en       = rsv;
      ifa.rsv_addr     = ra;
      c_rst = rst; c_we = we; c_wa = dst ? w1 : w0; c_wd = wd; c_rsv = rsv; c_ra = ra;
      if (!rst) begin
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) begin
               mem[m][i] = '0;
               bsy[m][i] = 1'b0;
            end
      end
      e.tag = tag;
      for (int m = 0; m < 2; m++) begin
         exp_rd(m, r0, e.d0[m], e.b0[m]);
         exp_rd(m, r1, e.d1[m], e.b1[m]);
         pc = 0;
         for (int i = 0; i < DEPTH; i++) pc += int'(bsy[m][i]);
         e.cnt[m] = pc[AW:0];
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            if (we && !(m == 0 && c_wa == 0)) begin
               mem[m][c_wa] = wd;
               bsy[m][c_wa] = 1'b0;
            end
            if (rsv && !(m == 0 && ra == 0)) bsy[m][ra] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
      step(1, 0, 0, 0, 0, '0, r0, r1, 0, 0, tag);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, " a.rd0_data"}, ifa.read0_data, e.d0[0]);
         chk({e.tag, " a.rd1_data"}, ifa.read1_data, e.d1[0]);
         chk({e.tag, " a.rd0_busy"}, DW'(ifa.read0_busy), DW'(e.b0[0]));
         chk({e.tag, " a.rd1_busy"}, DW'(ifa.read1_busy), DW'(e.b1[0]));
         chk({e.tag, " a.busy_count"}, DW'(ifa.busy_count), DW'(e.cnt[0]));
         chk({e.tag, " b.rd0_data"}, ifb.read0_data, e.d0[1]);
         chk({e.tag, " b.rd1_data"}, ifb.read1_data, e.d1[1]);
         chk({e.tag, " b.rd0_busy"}, DW'(ifb.read0_busy), DW'(e.b0[1]));
         chk({e.tag, " b.rd1_busy"}, DW'(ifb.read1_busy), DW'(e.b1[1]));
         chk({e.tag, " b.busy_count"}, DW'(ifb.busy_count), DW'(e.cnt[1]));
      end
   end

   initial begin
      logic [AW-1:0] w0, w1, ra, r0, r1;
      bit            dst;
      @(posedge clk);
      #1;
      // Reset held: activity must be ignored and everything reads zero.
      step(0, 1, 0, 1, 0, 32'hDEADBEEF, 1, 0, 1, 3, "rst_hold");
      // reg_dst selection, write-address-0 candidate untouched by the reg_dst=1 write.
      step(1, 1, 0, 1, 21, 32'h5ADFACED, 1, 21, 0, 0, "wr_dst0");
      step(1, 1, 1, 1, 21, 32'hEA770A57, 1, 21, 0, 0, "wr_dst1");
      idle(1, 21, "rd_back");
      // Async reset between edges.
      step(0, 0, 0, 0, 0, '0, 1, 21, 0, 0, "rst_mid");
      idle(1, 21, "post_rst");
      // Register 0 writes and reserves.
      step(1, 1, 0, 0, 9, 32'hFFFFFFFF, 0, 0, 1, 0, "zero_wr");
      idle(0, 0, "zero_rd");
      // Bypass visibility.
      step(1, 1, 1, 2, 5, 32'h12345678, 5, 6, 0, 0, "byp");
      idle(5, 5, "byp_after");
      // Scoreboard reserve/retire.
      step(1, 0, 0, 0, 0, '0, 3, 4, 1, 3, "sb_rsv3");
      step(1, 0, 0, 0, 0, '0, 3, 4, 1, 4, "sb_rsv4");
      step(1, 0, 0, 0, 0, '0, 3, 5, 1, 5, "sb_rsv5");
      idle(3, 5, "sb_cnt3");
      step(1, 1, 0, 4, 0, 32'hA5A5A5A5, 4, 3, 0, 0, "sb_wr4");
      idle(4, 3, "sb_r4");
      step(1, 1, 0, 3, 0, 32'h0BADF00D, 3, 4, 1, 3, "sb_same3");
      idle(3, 3, "sb_same_rd");
      // Fill every register, then one redundant reserve.
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, '0, AW'(i), 0, 1, AW'(i), "fill");
      idle(7, 31, "fill_full");
      step(1, 0, 0, 0, 0, '0, 7, 0, 1, 7, "fill_extra");
      idle(7, 0, "fill_after");
      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         dst = 1'($urandom_range(0, 1));
         w0  = AW'($urandom_range(0, DEPTH - 1));
         w1  = AW'($urandom_range(0, DEPTH - 1));
         ra  = ($urandom_range(0, 3) == 0) ? (dst ? w1 : w0) : AW'($urandom_range(0, DEPTH - 1));
         r0  = ($urandom_range(0, 1) == 0) ? (dst ? w1 : w0) : AW'($urandom_range(0, DEPTH - 1));
         r1  = ($urandom_range(0, 2) == 0) ? r0 : AW'($urandom_range(0, DEPTH - 1));
         step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), dst, w0, w1, $urandom,
              r0, r1, ($urandom_range(0, 4) < 2), ra, "rand");
      end
      idle(0, 1, "final");
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
